// File: rtl/conv_loop_controller.sv
// Convolution loop-nest sequencer: emits one registered MAC descriptor per
// valid/ready handshake in oy, ox, co, ky, kx, ci order (outer to inner).
module conv_loop_controller #(
  parameter int unsigned FEATURE_MAP_WIDTH  = 128,
  parameter int unsigned FEATURE_MAP_HEIGHT = 128,
  parameter int unsigned INPUT_NB_CHANNELS  = 2,
  parameter int unsigned OUTPUT_NB_CHANNELS = 16,
  parameter int unsigned KERNEL_SIZE        = 3,
  localparam int unsigned OXW = $clog2(FEATURE_MAP_WIDTH),
  localparam int unsigned OYW = $clog2(FEATURE_MAP_HEIGHT),
  localparam int unsigned XW  = OXW + 2,
  localparam int unsigned YW  = OYW + 2,
  localparam int unsigned CIW = (INPUT_NB_CHANNELS > 1) ? $clog2(INPUT_NB_CHANNELS) : 1,
  localparam int unsigned COW = (OUTPUT_NB_CHANNELS > 1) ? $clog2(OUTPUT_NB_CHANNELS) : 1,
  localparam int unsigned KW  = (KERNEL_SIZE > 1) ? $clog2(KERNEL_SIZE) : 1
) (
  input  logic           clk,
  input  logic           rst_in,
  input  logic           start,
  input  logic           conv_stride_mode,
  output logic           running,
  output logic           done,
  output logic           op_valid,
  input  logic           op_ready,
  output logic [XW-1:0]  op_in_x,
  output logic [YW-1:0]  op_in_y,
  output logic           op_pad,
  output logic [CIW-1:0] op_ci,
  output logic [COW-1:0] op_co,
  output logic [KW-1:0]  op_kx,
  output logic [KW-1:0]  op_ky,
  output logic           op_first,
  output logic           op_last,
  output logic [OXW-1:0] op_out_x,
  output logic [OYW-1:0] op_out_y
);

  localparam int unsigned W    = FEATURE_MAP_WIDTH;
  localparam int unsigned H    = FEATURE_MAP_HEIGHT;
  localparam int unsigned HALF = KERNEL_SIZE / 2;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t state;
  logic   stride2;

  logic           sel_s2;
  logic [CIW-1:0] n_ci;
  logic [COW-1:0] n_co;
  logic [KW-1:0]  n_kx, n_ky;
  logic [OXW-1:0] n_ox, ox_max;
  logic [OYW-1:0] n_oy, oy_max;
  logic [XW-1:0]  sx, n_ix;
  logic [YW-1:0]  sy, n_iy;
  logic           n_pad, n_first, n_last;
  logic           ci_end, kx_end, ky_end, co_end, ox_end, oy_end;
  logic           fire, final_op, load;

  assign ox_max = stride2 ? OXW'(W / 2 - 1) : OXW'(W - 1);
  assign oy_max = stride2 ? OYW'(H / 2 - 1) : OYW'(H - 1);

  assign ci_end = (op_ci == CIW'(INPUT_NB_CHANNELS - 1));
  assign kx_end = (op_kx == KW'(KERNEL_SIZE - 1));
  assign ky_end = (op_ky == KW'(KERNEL_SIZE - 1));
  assign co_end = (op_co == COW'(OUTPUT_NB_CHANNELS - 1));
  assign ox_end = (op_out_x == ox_max);
  assign oy_end = (op_out_y == oy_max);

  assign fire     = op_valid & op_ready;
  assign final_op = ci_end & kx_end & ky_end & co_end & ox_end & oy_end;
  assign load     = ((state == IDLE) & start) | ((state == RUN) & fire & ~final_op);

  // Next descriptor: zero on start, otherwise the carry-chained increment.
  always_comb begin
    n_ci = op_ci;
    n_kx = op_kx;
    n_ky = op_ky;
    n_co = op_co;
    n_ox = op_out_x;
    n_oy = op_out_y;
    sel_s2 = (state == IDLE) ? conv_stride_mode : stride2;
    if (state == IDLE) begin
      n_ci = '0;
      n_kx = '0;
      n_ky = '0;
      n_co = '0;
      n_ox = '0;
      n_oy = '0;
    end else if (!ci_end) begin
      n_ci = op_ci + CIW'(1);
    end else begin
      n_ci = '0;
      if (!kx_end) begin
        n_kx = op_kx + KW'(1);
      end else begin
        n_kx = '0;
        if (!ky_end) begin
          n_ky = op_ky + KW'(1);
        end else begin
          n_ky = '0;
          if (!co_end) begin
            n_co = op_co + COW'(1);
          end else begin
            n_co = '0;
            if (!ox_end) begin
              n_ox = op_out_x + OXW'(1);
            end else begin
              n_ox = '0;
              n_oy = oy_end ? '0 : op_out_y + OYW'(1);
            end
          end
        end
      end
    end
    // Stride 2 is a left shift; two's-complement wrap gives the signed result.
    sx      = sel_s2 ? {1'b0, n_ox, 1'b0} : {2'b00, n_ox};
    sy      = sel_s2 ? {1'b0, n_oy, 1'b0} : {2'b00, n_oy};
    n_ix    = sx + XW'(n_kx) - XW'(HALF);
    n_iy    = sy + YW'(n_ky) - YW'(HALF);
    n_pad   = n_ix[XW-1] | (n_ix >= XW'(W)) | n_iy[YW-1] | (n_iy >= YW'(H));
    n_first = (n_ky == '0) & (n_kx == '0) & (n_ci == '0);
    n_last  = (n_ky == KW'(KERNEL_SIZE - 1)) & (n_kx == KW'(KERNEL_SIZE - 1)) &
              (n_ci == CIW'(INPUT_NB_CHANNELS - 1));
  end

  // Control FSM with registered running/done/op_valid.
  always_ff @(posedge clk) begin
    if (rst_in) begin
      state    <= IDLE;
      stride2  <= 1'b0;
      running  <= 1'b0;
      done     <= 1'b0;
      op_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            stride2  <= conv_stride_mode;
            running  <= 1'b1;
            op_valid <= 1'b1;
            state    <= RUN;
          end
        end
        RUN: begin
          if (fire && final_op) begin
            running  <= 1'b0;
            op_valid <= 1'b0;
            done     <= 1'b1;
            state    <= DONE;
          end
        end
        DONE: begin
          done  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Descriptor registers double as the loop counters.
  always_ff @(posedge clk) begin
    if (rst_in) begin
      op_in_x  <= '0;
      op_in_y  <= '0;
      op_pad   <= 1'b0;
      op_ci    <= '0;
      op_co    <= '0;
      op_kx    <= '0;
      op_ky    <= '0;
      op_first <= 1'b0;
      op_last  <= 1'b0;
      op_out_x <= '0;
      op_out_y <= '0;
    end else if (load) begin
      op_in_x  <= n_ix;
      op_in_y  <= n_iy;
      op_pad   <= n_pad;
      op_ci    <= n_ci;
      op_co    <= n_co;
      op_kx    <= n_kx;
      op_ky    <= n_ky;
      op_first <= n_first;
      op_last  <= n_last;
      op_out_x <= n_ox;
      op_out_y <= n_oy;
    end
  end

endmodule

// File: tb/tb_conv_loop_controller.sv
// Bench for conv_loop_controller: captured descriptor streams are compared
// against a nested-loop reference list built from the loop-nest definition.
module tb_conv_loop_controller;

  localparam int W = 4, H = 4, CI = 2, CO = 2, K = 3;
  localparam int OXW = $clog2(W), OYW = $clog2(H);
  localparam int XW = OXW + 2, YW = OYW + 2;
  localparam int CIW = 1, COW = 1, KW = 2;

  logic clk = 1'b0, rst_in = 1'b1, start = 1'b0, conv_stride_mode = 1'b0, op_ready = 1'b0;
  logic running, done, op_valid, op_pad, op_first, op_last;
  logic [XW-1:0]  op_in_x;
  logic [YW-1:0]  op_in_y;
  logic [CIW-1:0] op_ci;
  logic [COW-1:0] op_co;
  logic [KW-1:0]  op_kx, op_ky;
  logic [OXW-1:0] op_out_x;
  logic [OYW-1:0] op_out_y;

  conv_loop_controller #(
    .FEATURE_MAP_WIDTH(W), .FEATURE_MAP_HEIGHT(H), .INPUT_NB_CHANNELS(CI),
    .OUTPUT_NB_CHANNELS(CO), .KERNEL_SIZE(K)
  ) dut (
    .clk(clk), .rst_in(rst_in), .start(start), .conv_stride_mode(conv_stride_mode),
    .running(running), .done(done), .op_valid(op_valid), .op_ready(op_ready),
    .op_in_x(op_in_x), .op_in_y(op_in_y), .op_pad(op_pad), .op_ci(op_ci), .op_co(op_co),
    .op_kx(op_kx), .op_ky(op_ky), .op_first(op_first), .op_last(op_last),
    .op_out_x(op_out_x), .op_out_y(op_out_y)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    int ox; int oy; int co; int ky; int kx; int ci; int ix; int iy;
    logic pad; logic first; logic last;
  } desc_t;

  desc_t exp_q[$], obs_q[$], hold_q[$];
  int  n_cmp = 0, n_fail = 0;
  int  done_cnt, done_bad, stall_bad, valid_drop, run_cycles;
  bit  first_valid, timeout;

  function automatic desc_t dut_desc();
    desc_t d;
    d.ox = int'(op_out_x); d.oy = int'(op_out_y); d.co = int'(op_co);
    d.ky = int'(op_ky); d.kx = int'(op_kx); d.ci = int'(op_ci);
    d.ix = int'($signed(op_in_x)); d.iy = int'($signed(op_in_y));
    d.pad = op_pad; d.first = op_first; d.last = op_last;
    return d;
  endfunction

  function automatic string fmt(desc_t d);
    return $sformatf("out(%0d,%0d) co%0d ky%0d kx%0d ci%0d in(%0d,%0d) pad%0b first%0b last%0b",
                     d.ox, d.oy, d.co, d.ky, d.kx, d.ci, d.ix, d.iy, d.pad, d.first, d.last);
  endfunction

  // Reference: the loop nest written out directly.
  function automatic void build_expected(int s);
    desc_t d;
    exp_q.delete();
    for (int oy = 0; oy < H / s; oy++)
      for (int ox = 0; ox < W / s; ox++)
        for (int co = 0; co < CO; co++)
          for (int ky = 0; ky < K; ky++)
            for (int kx = 0; kx < K; kx++)
              for (int ci = 0; ci < CI; ci++) begin
                d.ox = ox; d.oy = oy; d.co = co; d.ky = ky; d.kx = kx; d.ci = ci;
                d.ix = ox * s + kx - K / 2;
                d.iy = oy * s + ky - K / 2;
                d.pad = (d.ix < 0) || (d.ix >= W) || (d.iy < 0) || (d.iy >= H);
                d.first = (ky == 0) && (kx == 0) && (ci == 0);
                d.last = (ky == K - 1) && (kx == K - 1) && (ci == CI - 1);
                exp_q.push_back(d);
              end
  endfunction

  // Drives one run and records what the consumer side observes.
  task automatic run_capture(input bit mode, input int pct, input int stall_at,
                             input int start_at, input int reset_at);
    int acc = 0, stall_left = 0;
    bit stall_used = 0, prev_stall = 0;
    desc_t prev, cur;
    obs_q.delete(); hold_q.delete();
    done_cnt = 0; done_bad = 0; stall_bad = 0; valid_drop = 0; run_cycles = 0; timeout = 0;
    prev = '0;
    conv_stride_mode = mode;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    first_valid = op_valid;
    for (int cyc = 0; ; cyc++) begin
      if (cyc == 20000) begin timeout = 1; break; end
      if (reset_at > 0 && acc == reset_at) begin
        start = 1'b0; op_ready = 1'b0; rst_in = 1'b1;
        @(negedge clk);
        rst_in = 1'b0;
        return;
      end
      if (done) begin
        done_cnt++;
        if (running || op_valid) done_bad++;
        break;
      end
      cur = dut_desc();
      if (!op_valid) valid_drop++;
      if (prev_stall && cur !== prev) stall_bad++;
      start = (start_at > 0 && acc == start_at);
      if (stall_at > 0 && !stall_used && acc == stall_at - 1) begin
        stall_used = 1; stall_left = 10;
      end
      if (stall_left > 0) begin
        op_ready = 1'b0; hold_q.push_back(cur); stall_left--;
      end else begin
        op_ready = ($urandom_range(99) < pct);
      end
      if (op_valid && op_ready) begin obs_q.push_back(cur); acc++; end
      prev_stall = op_valid && !op_ready;
      prev = cur;
      run_cycles++;
      @(negedge clk);
    end
    start = 1'b0; op_ready = 1'b0;
    @(negedge clk);
    if (done || running) done_bad++;
  endtask

  task automatic test_reset();
    rst_in = 1'b1;
    repeat (2) @(negedge clk);
    n_cmp++;
    if ({running, done, op_valid, op_in_x, op_in_y, op_pad, op_ci, op_co, op_kx, op_ky,
         op_first, op_last, op_out_x, op_out_y} !== '0) begin
      n_fail++; $display("FAIL reset_outputs got valid=%b running=%b %s want all zero",
                         op_valid, running, fmt(dut_desc()));
    end
    rst_in = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (op_valid !== 1'b0 || running !== 1'b0) begin
      n_fail++; $display("FAIL idle_after_reset got valid=%b running=%b want 0 0", op_valid, running);
    end
  endtask

  task automatic test_stride1();
    build_expected(1);
    run_capture(1'b0, 100, 0, 0, 0);
    n_cmp++; if (first_valid !== 1'b1) begin n_fail++; $display("FAIL s1_valid_latency got %b want 1", first_valid); end
    n_cmp++; if (obs_q.size() != 576) begin n_fail++; $display("FAIL s1_count got %0d want 576", obs_q.size()); end
    n_cmp++; if (timeout) begin n_fail++; $display("FAIL s1_timeout got timeout want done"); end
    n_cmp++; if (done_cnt != 1 || done_bad != 0) begin n_fail++; $display("FAIL s1_done got pulses=%0d bad=%0d want 1 0", done_cnt, done_bad); end
    n_cmp++; if (run_cycles != 576 || valid_drop != 0) begin n_fail++; $display("FAIL s1_no_bubbles got cycles=%0d drops=%0d want 576 0", run_cycles, valid_drop); end
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
      n_cmp++;
      if (obs_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL s1_seq[%0d] got %s want %s", i, fmt(obs_q[i]), fmt(exp_q[i])); end
    end
    if (obs_q.size() >= 37) begin
      n_cmp++;
      if (obs_q[0].ix != -1 || obs_q[0].iy != -1 || !obs_q[0].pad || !obs_q[0].first)
        begin n_fail++; $display("FAIL s1_first_op got %s want in(-1,-1) pad1 first1", fmt(obs_q[0])); end
      n_cmp++;
      if (obs_q[17].ky != 2 || obs_q[17].kx != 2 || obs_q[17].ci != 1 || !obs_q[17].last ||
          obs_q[17].ix != 1 || obs_q[17].iy != 1 || obs_q[17].pad)
        begin n_fail++; $display("FAIL s1_accept18 got %s want ky2 kx2 ci1 in(1,1) pad0 last1", fmt(obs_q[17])); end
      n_cmp++;
      if (obs_q[18].co != 1 || !obs_q[18].first)
        begin n_fail++; $display("FAIL s1_accept19 got %s want co1 first1", fmt(obs_q[18])); end
      n_cmp++;
      if (obs_q[36].ox != 1 || obs_q[36].oy != 0 || obs_q[36].co != 0 || obs_q[36].ix != 0)
        begin n_fail++; $display("FAIL s1_accept37 got %s want out(1,0) co0 in_x0", fmt(obs_q[36])); end
    end
  endtask

  task automatic test_stride2();
    int found = 0;
    build_expected(2);
    run_capture(1'b1, 100, 0, 0, 0);
    n_cmp++; if (obs_q.size() != 144) begin n_fail++; $display("FAIL s2_count got %0d want 144", obs_q.size()); end
    n_cmp++; if (done_cnt != 1 || done_bad != 0 || timeout) begin n_fail++; $display("FAIL s2_done got pulses=%0d bad=%0d to=%0b want 1 0 0", done_cnt, done_bad, timeout); end
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
      n_cmp++;
      if (obs_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL s2_seq[%0d] got %s want %s", i, fmt(obs_q[i]), fmt(exp_q[i])); end
    end
    foreach (obs_q[i])
      if (obs_q[i].ox == 1 && obs_q[i].oy == 0 && obs_q[i].ky == 1 && obs_q[i].kx == 1) begin
        found++;
        n_cmp++;
        if (obs_q[i].ix != 2) begin n_fail++; $display("FAIL s2_centre_tap got in_x=%0d want 2", obs_q[i].ix); end
      end
    n_cmp++; if (found != 4) begin n_fail++; $display("FAIL s2_centre_tap_count got %0d want 4", found); end
    if (obs_q.size() > 0) begin
      n_cmp++;
      if (obs_q[$].ox != 1 || obs_q[$].oy != 1 || obs_q[$].co != 1 || obs_q[$].ix != 3 ||
          obs_q[$].iy != 3 || obs_q[$].pad)
        begin n_fail++; $display("FAIL s2_last_op got %s want out(1,1) co1 in(3,3) pad0", fmt(obs_q[$])); end
    end
  endtask

  task automatic test_backpressure();
    bit mode;
    mode = 1'($urandom_range(1));
    build_expected(mode ? 2 : 1);
    run_capture(mode, 50, 0, 0, 0);
    n_cmp++; if (obs_q.size() != exp_q.size()) begin n_fail++; $display("FAIL bp_count got %0d want %0d", obs_q.size(), exp_q.size()); end
    n_cmp++; if (stall_bad != 0 || valid_drop != 0) begin n_fail++; $display("FAIL bp_stable got changes=%0d drops=%0d want 0 0", stall_bad, valid_drop); end
    n_cmp++; if (done_cnt != 1 || done_bad != 0 || timeout) begin n_fail++; $display("FAIL bp_done got pulses=%0d bad=%0d to=%0b want 1 0 0", done_cnt, done_bad, timeout); end
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
      n_cmp++;
      if (obs_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL bp_seq[%0d] got %s want %s", i, fmt(obs_q[i]), fmt(exp_q[i])); end
    end
  endtask

  task automatic test_stall();
    build_expected(1);
    run_capture(1'b0, 100, 5, 0, 0);
    n_cmp++; if (hold_q.size() != 10) begin n_fail++; $display("FAIL stall_len got %0d want 10", hold_q.size()); end
    foreach (hold_q[i]) begin
      n_cmp++;
      if (hold_q[i] !== exp_q[4]) begin n_fail++; $display("FAIL stall_hold[%0d] got %s want %s", i, fmt(hold_q[i]), fmt(exp_q[4])); end
    end
    n_cmp++; if (obs_q.size() != 576) begin n_fail++; $display("FAIL stall_count got %0d want 576", obs_q.size()); end
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
      n_cmp++;
      if (obs_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL stall_seq[%0d] got %s want %s", i, fmt(obs_q[i]), fmt(exp_q[i])); end
    end
  endtask

  task automatic test_ignored_start();
    build_expected(1);
    run_capture(1'b0, 100, 0, 50, 0);
    n_cmp++; if (obs_q.size() != 576) begin n_fail++; $display("FAIL ign_start_count got %0d want 576", obs_q.size()); end
    n_cmp++; if (done_cnt != 1 || done_bad != 0) begin n_fail++; $display("FAIL ign_start_done got pulses=%0d bad=%0d want 1 0", done_cnt, done_bad); end
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
      n_cmp++;
      if (obs_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL ign_start_seq[%0d] got %s want %s", i, fmt(obs_q[i]), fmt(exp_q[i])); end
    end
  endtask

  task automatic test_mid_reset();
    int done_seen = 0;
    run_capture(1'b0, 100, 0, 0, 100);
    n_cmp++;
    if ({running, done, op_valid, op_in_x, op_in_y, op_pad, op_ci, op_co, op_kx, op_ky,
         op_first, op_last, op_out_x, op_out_y} !== '0) begin
      n_fail++; $display("FAIL midrst_outputs got valid=%b running=%b %s want all zero",
                         op_valid, running, fmt(dut_desc()));
    end
    repeat (4) begin
      if (done || op_valid) done_seen++;
      @(negedge clk);
    end
    n_cmp++; if (done_seen != 0) begin n_fail++; $display("FAIL midrst_no_done got %0d active cycles want 0", done_seen); end
    build_expected(1);
    run_capture(1'b0, 100, 0, 0, 0);
    n_cmp++; if (obs_q.size() != 576 || done_cnt != 1) begin n_fail++; $display("FAIL midrst_rerun got count=%0d pulses=%0d want 576 1", obs_q.size(), done_cnt); end
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
      n_cmp++;
      if (obs_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL midrst_seq[%0d] got %s want %s", i, fmt(obs_q[i]), fmt(exp_q[i])); end
    end
  endtask

  initial begin
    test_reset();
    test_stride1();
    test_stride2();
    test_backpressure();
    test_stall();
    test_ignored_start();
    test_mid_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/conv_loop_controller.md
Name: conv_loop_controller

Overview:
- Sequences the convolution loop nest for the accelerator datapath.
- Emits one MAC-operation descriptor per handshake: input coordinate, padding flag, channel and kernel indices, and accumulate first/last flags.
- Sits between top-level start/config and the operand fetch and MAC units, replacing ad-hoc counters inside top_system.
- Loop order, outer to inner: oy, ox, co, ky, kx, ci.

Parameters:
FEATURE_MAP_WIDTH, 128, input map width W (even)
FEATURE_MAP_HEIGHT, 128, input map height H (even)
INPUT_NB_CHANNELS, 2, input channels CI
OUTPUT_NB_CHANNELS, 16, output channels CO
KERNEL_SIZE, 3, kernel edge K (odd)

Ports:
clk  input  1  clock
rst_in  input  1  synchronous active-high reset
start  input  1  start pulse, honoured in IDLE only
conv_stride_mode  input  1  0: stride 1, 1: stride 2; latched at start
running  output  1  high while in RUN
done  output  1  one-cycle pulse after the final op is accepted
op_valid  output  1  descriptor valid
op_ready  input  1  consumer accepts descriptor
op_in_x  output  $clog2(W)+2  signed input x = ox*S + kx - K/2
op_in_y  output  $clog2(H)+2  signed input y = oy*S + ky - K/2
op_pad  output  1  input coordinate outside map; consumer uses 0 operand
op_ci  output  $clog2(CI) (min 1)  input channel
op_co  output  $clog2(CO) (min 1)  output channel
op_kx, op_ky  output  $clog2(K)  kernel indices
op_first  output  1  first op of this (ox,oy,co) accumulation
op_last  output  1  last op of this accumulation; result is complete
op_out_x  output  $clog2(W)  output pixel x
op_out_y  output  $clog2(H)  output pixel y

Behaviour:
- Reset (synchronous, rst_in=1 at a clk edge):
  - FSM goes to IDLE; all counters are 0.
  - Every output is 0, including op_in_x/op_in_y (pad recomputed on start).
  - Applies mid-operation too: no further descriptors are issued and done does not pulse.
- FSM states IDLE, RUN, DONE:
  - IDLE: start=1 latches stride S (1 or 2), clears counters, goes to RUN.
  - RUN: op_valid=1 from the first RUN cycle, i.e. one cycle after start is sampled. running=1.
  - RUN to DONE: when the op with oy,ox,co,ky,kx,ci all at their max is accepted.
  - DONE: done=1, running=0, op_valid=0 for exactly one cycle, then IDLE.
  - start in RUN or DONE is ignored.
- Output dimensions: OW = W/S, OH = H/S (same-padding).
- Total accepted ops per run: OH*OW*CO*K*K*CI.
- Handshake:
  - Counters advance only on op_valid & op_ready.
  - While op_valid=1 and op_ready=0, every op_* output holds stable.
  - op_valid never drops in RUN until the final op is accepted.
  - op_ready is ignored outside RUN.
- Counter wrap: innermost ci wraps to 0 and carries into kx, then ky, co, ox, oy.
- op_first = (ky==0 & kx==0 & ci==0).
- op_last = (ky==K-1 & kx==K-1 & ci==CI-1).
- op_pad = op_in_x<0 | op_in_x>=W | op_in_y<0 | op_in_y>=H.
- All op_* outputs are registered. The next descriptor is precomputed so that back-to-back acceptance (op_ready held 1) yields one op per cycle with no bubbles.
- Arithmetic:
  - op_in_x/op_in_y use signed arithmetic at the declared width.
  - ox*S is implemented as ox or ox<<1.
  - No multiplier is instantiated.

Test Plan:
- Basic stride 1 (W=H=4, CI=2, CO=2, K=3; mode 0, start pulse, op_ready=1):
  - op_valid rises 1 cycle after start.
  - First op: out(0,0), co0, ky0, kx0, ci0, in(-1,-1), pad=1, first=1.
  - Exactly 576 accepts, then done pulses 1 cycle; running falls the same cycle.
- Accumulation boundary (same setup):
  - Accept #18 has ky2, kx2, ci1, last=1, in(1,1), pad=0.
  - Accept #19 has co1, first=1.
  - Accept #37 has out(1,0), co0, in_x=0.
- Stride 2 (mode 1, same setup):
  - Exactly 144 accepts.
  - out_x sequence per row is 0,1. Pixel out(1,0) centre tap (ky1,kx1) has in_x=2.
  - Last op is out(1,1), co1, in(3,3), pad=0.
- Back-pressure:
  - op_ready random 50%: no descriptor is skipped or duplicated, and outputs are stable while stalled.
  - op_ready=0 for 10 cycles at accept #5: outputs hold the #5 values for all 10 cycles.
- Ignored start and mid-run reset:
  - start pulsed during RUN: no restart, count stays 576.
  - rst_in asserted at accept #100: next cycle all outputs 0, IDLE, no done pulse.
  - A new start then runs a full 576-op sequence.
